fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 8-bit pipelined CPU; directly upstream of decode.
//   Owns the PC, reads bytes from the shared unified memory, assembles 1- and 2-byte
//   instructions (opcode 4'hC = LDM/LDD/STD carries an operand byte), and presents
//   them to decode through a registered IF/ID output with valid/stall handshake.
//   Also loads the reset vector (M[0]) and the interrupt vector (M[1]).
// PARAMETERS
//   AW        8      PC / memory address width
//   DW        8      instruction byte width
//   RST_VEC   8'h00  address holding the reset vector
//   INT_VEC   8'h01  address holding the interrupt vector
// PORTS
//   clk         in   1   rising-edge clock
//   rstn        in   1   asynchronous active-low reset
//   mem_addr    out  AW  fetch address to unified memory (combinational read)
//   mem_rdata   in   DW  byte at mem_addr, valid same cycle
//   mem_busy    in   1   memory stage owns the port this cycle; fetch must not advance
//   id_stall    in   1   decode cannot accept; hold IF/ID output
//   redir_en    in   1   branch/jump/RET redirect from execute (priority over all but reset)
//   redir_pc    in   AW  redirect target
//   int_sig     in   1   external interrupt request (level, sampled every cycle)
//   if_valid    out  1   IF/ID register holds a complete instruction
//   if_instr    out  DW  opcode byte
//   if_imm      out  DW  operand byte (2-byte instructions only, else 8'h00)
//   if_pc_next  out  AW  address following the instruction (return/link value)
//   if_int      out  1   marks the injected interrupt pseudo-instruction
// BEHAVIOUR
//   Reset: PC=0, state=S_VEC, if_valid=0, if_instr=0, if_imm=0, if_pc_next=0,
//     if_int=0, int_pend=0. mem_addr=RST_VEC while in S_VEC.
//   "Advance" = !mem_busy && !(if_valid && id_stall). No state/PC change otherwise.
//   States:
//     S_VEC : mem_addr=RST_VEC; on advance PC<=mem_rdata -> S_OP. Nothing emitted.
//     S_OP  : mem_addr=PC. If int_pend: emit if_int=1, if_instr=0, if_pc_next=PC,
//             clear int_pend -> S_IVEC. Else if mem_rdata[7:4]==4'hC: opcode latched
//             to hold reg, PC<=PC+1 -> S_IMM (if_valid<=0). Else emit 1-byte instr,
//             if_imm=0, if_pc_next=PC+1, PC<=PC+1, stay S_OP.
//     S_IMM : mem_addr=PC; emit {held opcode, mem_rdata}, if_pc_next=PC+1,
//             PC<=PC+1 -> S_OP.
//     S_IVEC: mem_addr=INT_VEC; PC<=mem_rdata -> S_OP. Nothing emitted.
//   Emit = if_valid<=1 with fields loaded; a cycle with advance but no emit sets
//     if_valid<=0. When !advance all outputs hold (if_valid stays as-is).
//   Latency: 1-byte instr visible on if_* the cycle after its byte is read; 2-byte
//     after two fetch cycles. Sustained rate 1 byte/cycle absent stalls.
//   PC arithmetic is modulo 2^AW: PC=8'hFF +1 wraps to 8'h00; a 2-byte instr at
//     8'hFF takes its operand from 8'h00.
//   int_pend sets on int_sig=1 any cycle; taken only in S_OP (instruction boundary),
//     never between opcode and operand. Held through stalls; not set while if_int
//     pseudo-instr is being emitted in the same cycle it is cleared (clear wins).
//   redir_en (sampled every cycle, ignores mem_busy/id_stall): PC<=redir_pc,
//     state<=S_OP, if_valid<=0, held opcode discarded (partial 2-byte squashed).
//     int_pend is retained. redir_en in S_VEC/S_IVEC overrides vector load.
//   rstn low mid-instruction: immediate return to reset state; partial fetch lost.
// TESTING
//   Reset with M[0]=8'h02, M[2]=8'h10 (1-byte), M[3]=8'hC5, M[4]=8'hF0 -> first
//     emit instr=10 pc_next=03; next emit instr=C5 imm=F0 pc_next=05; no emit between.
//   id_stall=1 for 3 cycles while if_valid=1 -> if_* held constant, PC unchanged;
//     release -> stream resumes with no lost or duplicated instruction.
//   mem_busy=1 during S_IMM of C5 F0 -> operand read deferred; emit C5/F0 after drop.
//   int_sig pulse during S_IMM, M[1]=8'h40 -> C5/F0 emitted first, then if_int=1
//     with pc_next=next PC, then fetch from 8'h40.
//   redir_en with redir_pc=8'h20 in S_IMM -> no C5 emit, if_valid=0 next cycle,
//     next fetch at 8'h20; PC at 8'hFF with 1-byte instr -> pc_next=8'h00, wrap.
//   rstn pulsed low in S_IMM -> all outputs 0 asynchronously; restart from M[0].

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage port bundle: unified-memory read port, IF/ID output, redirect and interrupt inputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy;
  logic          id_stall;
  logic          redir_en;
  logic [AW-1:0] redir_pc;
  logic          int_sig;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [DW-1:0] if_imm;
  logic [AW-1:0] if_pc_next;
  logic          if_int;

  modport master (
    output mem_addr, if_valid, if_instr, if_imm, if_pc_next, if_int,
    input  mem_rdata, mem_busy, id_stall, redir_en, redir_pc, int_sig
  );

  modport slave (
    input  mem_addr, if_valid, if_instr, if_imm, if_pc_next, if_int,
    output mem_rdata, mem_busy, id_stall, redir_en, redir_pc, int_sig
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, assembles 1/2-byte instructions into a registered IF/ID slot.
// 1-byte instr visible the cycle after its byte is read; holds on mem_busy or stalled valid output.
module fetch_stage #(
  parameter int            AW      = 8,
  parameter int            DW      = 8,
  parameter logic [AW-1:0] RST_VEC = '0,
  parameter logic [AW-1:0] INT_VEC = AW'(1)
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {S_VEC, S_OP, S_IMM, S_IVEC} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] op_q, op_d;
  logic          int_pend_q, int_pend_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [AW-1:0] pcn_q, pcn_d;
  logic          int_q, int_d;
  logic [AW-1:0] mem_addr;
  logic          advance;
  logic          is_two_byte;

  assign advance     = !bus.mem_busy && !(valid_q && bus.id_stall);
  assign is_two_byte = (bus.mem_rdata[DW-1 -: 4] == 4'hC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    int_pend_d = int_pend_q | bus.int_sig;
    valid_d    = valid_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    pcn_d      = pcn_q;
    int_d      = int_q;

    case (state_q)
      S_VEC:   mem_addr = RST_VEC;
      S_IVEC:  mem_addr = INT_VEC;
      default: mem_addr = pc_q;
    endcase

    // Redirect squashes any partial 2-byte fetch and wins over stalls and vector loads.
    if (bus.redir_en) begin
      pc_d    = bus.redir_pc;
      state_d = S_OP;
      valid_d = 1'b0;
      op_d    = '0;
    end else if (advance) begin
      valid_d = 1'b0;
      case (state_q)
        S_VEC, S_IVEC: begin
          pc_d    = AW'(bus.mem_rdata);
          state_d = S_OP;
        end
        S_OP: begin
          if (int_pend_q) begin
            valid_d    = 1'b1;
            int_d      = 1'b1;
            instr_d    = '0;
            imm_d      = '0;
            pcn_d      = pc_q;
            int_pend_d = 1'b0;
            state_d    = S_IVEC;
          end else if (is_two_byte) begin
            op_d    = bus.mem_rdata;
            pc_d    = pc_q + AW'(1);
            state_d = S_IMM;
          end else begin
            valid_d = 1'b1;
            int_d   = 1'b0;
            instr_d = bus.mem_rdata;
            imm_d   = '0;
            pcn_d   = pc_q + AW'(1);
            pc_d    = pc_q + AW'(1);
          end
        end
        S_IMM: begin
          valid_d = 1'b1;
          int_d   = 1'b0;
          instr_d = op_q;
          imm_d   = bus.mem_rdata;
          pcn_d   = pc_q + AW'(1);
          pc_d    = pc_q + AW'(1);
          state_d = S_OP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_VEC;
      pc_q       <= '0;
      op_q       <= '0;
      int_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      imm_q      <= '0;
      pcn_q      <= '0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      int_pend_q <= int_pend_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      pcn_q      <= pcn_d;
      int_q      <= int_d;
    end
  end

  assign bus.mem_addr   = mem_addr;
  assign bus.if_valid   = valid_q;
  assign bus.if_instr   = instr_q;
  assign bus.if_imm     = imm_q;
  assign bus.if_pc_next = pcn_q;
  assign bus.if_int     = int_q;

endmodule
